// File: rtl/dram_phase_sequencer.sv
// DRAM half-phi strobe generator: 32-tick phi counter with phi_sync realignment and six offset strobes.
// Define DRAM_TIMING_CFG_EN for the double-buffered offset config port; otherwise offsets are DEF_*.
module dram_phase_sequencer #(
   parameter logic [3:0] DEF_ROW = 4'd4,
   parameter logic [3:0] DEF_RHL = 4'd5,
   parameter logic [3:0] DEF_COL = 4'd6,
   parameter logic [3:0] DEF_CHL = 4'd7,
   parameter logic [3:0] DEF_RLH = 4'd14,
   parameter logic [3:0] DEF_CLH = 4'd14
) (
   input  logic       clk_dot4x,
   input  logic       rst,
   input  logic       phi_sync,
   input  logic       enable,
   input  logic       cfg_we,
   input  logic [2:0] cfg_addr,
   input  logic [3:0] cfg_data,
   output logic       cfg_pending,
   output logic       cfg_err,
   output logic       sync_err,
   output logic [4:0] phase_tick,
   output logic       phi,
   output logic       phi_phase_start_row,
   output logic       phi_phase_start_rhl,
   output logic       phi_phase_start_col,
   output logic       phi_phase_start_chl,
   output logic       phi_phase_start_rlh,
   output logic       phi_phase_start_clh
);

   localparam logic [5:0][3:0] DEF_OFFS = {DEF_CLH, DEF_RLH, DEF_CHL, DEF_COL, DEF_RHL, DEF_ROW};

   logic [4:0]      tick_q, tick_d;
   logic            phi_q, phi_d;
   logic            sync_err_q, sync_err_d;
   logic [5:0]      strobe_q, strobe_d;
   logic            wrap;
   logic [5:0][3:0] offs_d;

   always_comb begin
      tick_d     = phi_sync ? 5'd0 : tick_q + 5'd1;
      wrap       = (tick_d == 5'd0);
      phi_d      = tick_d[4];
      sync_err_d = phi_sync && (tick_q != 5'd31);
   end

`ifdef DRAM_TIMING_CFG_EN
   logic [5:0][3:0] shadow_q, shadow_d, active_q, cand;
   logic            cfg_pending_q, cfg_pending_d, cfg_err_q, cfg_err_d, accept;

   // Offsets only switch at the period boundary; a write landing on that same edge is bypassed in.
   always_comb begin
      cand = shadow_q;
      if (cfg_addr <= 3'd5) begin
         cand[cfg_addr] = cfg_data;
      end
      accept = cfg_we && (cfg_addr <= 3'd5) &&
               (cand[0] < cand[1]) && (cand[1] < cand[2]) && (cand[2] < cand[3]) &&
               (cand[3] < cand[4]) && (cand[3] < cand[5]);
      shadow_d      = accept ? cand : shadow_q;
      offs_d        = wrap ? shadow_d : active_q;
      cfg_pending_d = wrap ? 1'b0 : (cfg_pending_q | accept);
      cfg_err_d     = cfg_we && !accept;
   end

   always_ff @(posedge clk_dot4x or negedge rst) begin
      if (!rst) begin
         shadow_q      <= DEF_OFFS;
         active_q      <= DEF_OFFS;
         cfg_pending_q <= 1'b0;
         cfg_err_q     <= 1'b0;
      end else begin
         shadow_q      <= shadow_d;
         active_q      <= offs_d;
         cfg_pending_q <= cfg_pending_d;
         cfg_err_q     <= cfg_err_d;
      end
   end

   assign cfg_pending = cfg_pending_q;
   assign cfg_err     = cfg_err_q;
`else
   logic cfg_unused;

   assign cfg_unused  = ^{cfg_we, cfg_addr, cfg_data};
   assign offs_d      = DEF_OFFS;
   assign cfg_pending = 1'b0;
   assign cfg_err     = 1'b0;
`endif

   // Decode from the next tick so each strobe lines up with the phase_tick it belongs to.
   always_comb begin
      strobe_d = '0;
      for (int i = 0; i < 6; i++) begin
         strobe_d[i] = enable && (tick_d[3:0] == offs_d[i]);
      end
   end

   always_ff @(posedge clk_dot4x or negedge rst) begin
      if (!rst) begin
         tick_q     <= 5'd31;
         phi_q      <= 1'b1;
         sync_err_q <= 1'b0;
         strobe_q   <= '0;
      end else begin
         tick_q     <= tick_d;
         phi_q      <= phi_d;
         sync_err_q <= sync_err_d;
         strobe_q   <= strobe_d;
      end
   end

   assign phase_tick          = tick_q;
   assign phi                 = phi_q;
   assign sync_err            = sync_err_q;
   assign phi_phase_start_row = strobe_q[0];
   assign phi_phase_start_rhl = strobe_q[1];
   assign phi_phase_start_col = strobe_q[2];
   assign phi_phase_start_chl = strobe_q[3];
   assign phi_phase_start_rlh = strobe_q[4];
   assign phi_phase_start_clh = strobe_q[5];

endmodule

// File: tb/tb_dram_phase_sequencer.sv
// Scoreboard bench for dram_phase_sequencer: driver pushes expected outputs per cycle, monitor pops and compares.
// Expectations follow DRAM_TIMING_CFG_EN the same way the design does.
module tb_dram_phase_sequencer;

   typedef struct packed {
      logic [4:0] tick;
      logic       phi;
      logic [5:0] strb;
      logic       pend;
      logic       err;
      logic       serr;
   } exp_t;

   localparam logic [5:0][3:0] M_DEF = {4'd14, 4'd14, 4'd7, 4'd6, 4'd5, 4'd4};

   logic       clk_dot4x;
   logic       rst;
   logic       phi_sync;
   logic       enable;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [3:0] cfg_data;
   logic       cfg_pending, cfg_err, sync_err, phi;
   logic [4:0] phase_tick;
   logic       s_row, s_rhl, s_col, s_chl, s_rlh, s_clh;
   logic [5:0] strb_act;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t exp_q[$];

   logic [4:0]      m_tick;
   logic [5:0][3:0] m_act, m_sh;
   logic            m_pend;

   dram_phase_sequencer dut (
      .clk_dot4x           (clk_dot4x),
      .rst                 (rst),
      .phi_sync            (phi_sync),
      .enable              (enable),
      .cfg_we              (cfg_we),
      .cfg_addr            (cfg_addr),
      .cfg_data            (cfg_data),
      .cfg_pending         (cfg_pending),
      .cfg_err             (cfg_err),
      .sync_err            (sync_err),
      .phase_tick          (phase_tick),
      .phi                 (phi),
      .phi_phase_start_row (s_row),
      .phi_phase_start_rhl (s_rhl),
      .phi_phase_start_col (s_col),
      .phi_phase_start_chl (s_chl),
      .phi_phase_start_rlh (s_rlh),
      .phi_phase_start_clh (s_clh)
   );

   assign strb_act = {s_clh, s_rlh, s_chl, s_col, s_rhl, s_row};

   initial clk_dot4x = 1'b0;
   always #5 clk_dot4x = ~clk_dot4x;

   task automatic checkOutput(input string name, input int act, input int req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, req);
      end
   endtask

   task automatic modelReset();
      m_tick = 5'd31;
      m_act  = M_DEF;
      m_sh   = M_DEF;
      m_pend = 1'b0;
   endtask

   // Drive one cycle of inputs at a falling edge, predict the outputs after the next rising edge.
   task automatic applyStimulus(input logic ps, input logic en, input logic we,
                                input logic [2:0] addr, input logic [3:0] data);
      exp_t            e;
      logic [4:0]      nt;
      logic [5:0][3:0] cand;
      logic            ok;
      phi_sync = ps;
      enable   = en;
      cfg_we   = we;
      cfg_addr = addr;
      cfg_data = data;
      nt     = ps ? 5'd0 : m_tick + 5'd1;
      e      = '0;
      e.serr = ps && (m_tick != 5'd31);
`ifdef DRAM_TIMING_CFG_EN
      cand = m_sh;
      ok   = 1'b0;
      if (we) begin
         if (addr <= 3'd5) begin
            cand[addr] = data;
            ok = (cand[0] < cand[1]) && (cand[1] < cand[2]) && (cand[2] < cand[3]) &&
                 (cand[3] < cand[4]) && (cand[3] < cand[5]);
         end
         e.err = !ok;
      end
      if (ok) m_sh = cand;
      if (nt == 5'd0) begin
         m_act  = m_sh;
         m_pend = 1'b0;
      end else if (ok) begin
         m_pend = 1'b1;
      end
`else
      cand = M_DEF;
      ok   = 1'b0;
      m_act = cand;
`endif
      e.pend = m_pend;
      e.tick = nt;
      e.phi  = nt[4];
      for (int i = 0; i < 6; i++) e.strb[i] = en && (nt[3:0] == m_act[i]);
      exp_q.push_back(e);
      m_tick = nt;
      @(negedge clk_dot4x);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
   endtask

   task automatic gotoTick(input logic [4:0] t);
      for (int i = 0; i < 33 && m_tick != t; i++) applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_tick"},  phase_tick,  31);
      checkOutput({tag, "_phi"},   phi,         1);
      checkOutput({tag, "_strb"},  strb_act,    0);
      checkOutput({tag, "_pend"},  cfg_pending, 0);
      checkOutput({tag, "_err"},   cfg_err,     0);
      checkOutput({tag, "_serr"},  sync_err,    0);
   endtask

   // Monitor: every rising edge with an outstanding prediction is compared shortly after the edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_dot4x);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("phase_tick",  phase_tick,  e.tick);
            checkOutput("phi",         phi,         e.phi);
            checkOutput("strobes",     strb_act,    e.strb);
            checkOutput("cfg_pending", cfg_pending, e.pend);
            checkOutput("cfg_err",     cfg_err,     e.err);
            checkOutput("sync_err",    sync_err,    e.serr);
         end
      end
   end

   initial begin
      phi_sync = 1'b0;
      enable   = 1'b1;
      cfg_we   = 1'b0;
      cfg_addr = 3'd0;
      cfg_data = 4'd0;
      rst      = 1'b1;
      modelReset();
      #1 rst = 1'b0;
      #2 checkResetState("reset");
      @(negedge clk_dot4x);
      rst = 1'b1;

      $display("[TB] default period");
      idle(32);

      $display("[TB] phi_sync off-phase and aligned");
      gotoTick(5'd9);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      gotoTick(5'd31);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);

      $display("[TB] config writes: CHL=10, COL=9, rejected RHL=10 and reserved addresses");
      gotoTick(5'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 4'd10);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd2, 4'd9);
      idle(1);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd1, 4'd10);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd7, 4'd1);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd6, 4'd2);
      idle(64);

      $display("[TB] pending write applied by phi_sync load");
      gotoTick(5'd20);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 4'd3);
      gotoTick(5'd25);
      applyStimulus(1'b1, 1'b1, 1'b0, 3'd0, 4'd0);
      idle(40);

      $display("[TB] write at tick 31 bypasses into next period");
      gotoTick(5'd31);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd3, 4'd11);
      idle(32);

      $display("[TB] async reset with pending write");
      gotoTick(5'd5);
      applyStimulus(1'b0, 1'b1, 1'b1, 3'd0, 4'd2);
      gotoTick(5'd12);
      phi_sync = 1'b0;
      cfg_we   = 1'b0;
      rst      = 1'b0;
      #1 checkResetState("midreset");
      modelReset();
      @(negedge clk_dot4x);
      @(negedge clk_dot4x);
      rst = 1'b1;
      idle(32);

      $display("[TB] enable low for first half");
      gotoTick(5'd31);
      for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b0, 1'b0, 3'd0, 4'd0);
      idle(18);

      #7;
      checkOutput("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
